// File: rtl/tone_sequencer.sv
// Note-table walker that feeds the square-wave pulse generator with lengths, mute and phase restarts.
// Optional inter-note muted gap is compiled in with the SEQ_GAP_EN macro.
module tone_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int TICK_DIV     = 50000,
    parameter int PERIOD_SHIFT = 4,
    parameter int GAP_TICKS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       length1,
    output logic [31:0]       length2,
    output logic              mute,
    output logic              pulse_rst,
    output logic              busy,
    output logic              done
);

`ifdef SEQ_GAP_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;
`endif

    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t           state;
    logic [PRE_W-1:0] prescaler;
    logic [14:0]      dur_cnt;

    logic        is_end;
    logic [14:0] note_dur;
    logic [15:0] half;
    logic [31:0] note_len;
    logic        tick;

    assign is_end   = rom_data[31];
    assign note_dur = rom_data[30:16];
    assign half     = rom_data[15:0];
    assign note_len = ({16'd0, half} << PERIOD_SHIFT) - 32'd1;
    assign tick     = (prescaler == PRE_LAST);
    assign busy     = (state != IDLE);

    // stop outranks everything outside IDLE, including an end marker seen in LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rom_addr  <= '0;
            length1   <= 32'd0;
            length2   <= 32'd0;
            mute      <= 1'b1;
            pulse_rst <= 1'b0;
            done      <= 1'b0;
            prescaler <= '0;
            dur_cnt   <= 15'd0;
        end else begin
            pulse_rst <= 1'b0;
            done      <= 1'b0;
            if (stop && state != IDLE) begin
                state <= IDLE;
                mute  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            rom_addr <= start_addr;
                            state    <= FETCH;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        if (is_end) begin
                            if (loop) begin
                                rom_addr <= start_addr;
                                state    <= FETCH;
                            end else begin
                                mute  <= 1'b1;
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end else if (note_dur == 15'd0) begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= FETCH;
                        end else begin
                            if (half != 16'd0) begin
                                length1   <= note_len;
                                length2   <= note_len;
                                mute      <= 1'b0;
                                pulse_rst <= 1'b1;
                            end else begin
                                mute <= 1'b1;
                            end
                            prescaler <= '0;
                            dur_cnt   <= note_dur;
                            state     <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            prescaler <= '0;
                            dur_cnt   <= dur_cnt - 15'd1;
                            if (dur_cnt == 15'd1) begin
                                rom_addr <= rom_addr + ADDR_W'(1);
`ifdef SEQ_GAP_EN
                                if (GAP_TICKS > 0) begin
                                    mute    <= 1'b1;
                                    dur_cnt <= 15'(GAP_TICKS);
                                    state   <= GAP;
                                end else begin
                                    state <= FETCH;
                                end
`else
                                state <= FETCH;
`endif
                            end
                        end else begin
                            prescaler <= prescaler + PRE_W'(1);
                        end
                    end
`ifdef SEQ_GAP_EN
                    GAP: begin
                        if (tick) begin
                            prescaler <= '0;
                            dur_cnt   <= dur_cnt - 15'd1;
                            if (dur_cnt == 15'd1) begin
                                state <= FETCH;
                            end
                        end else begin
                            prescaler <= prescaler + PRE_W'(1);
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Upstream feeder for the square-wave pulse generator in the game audio path.
- Walks a note table held in an external synchronous ROM.
- For each note it drives the generator's high and low count inputs (length1/length2), a mute flag, and a one-cycle phase-restart strobe (pulse_rst).
- It holds each note for a programmed number of timebase ticks, then fetches the next entry. Supports stop, end-of-song and loop.

Parameters:
ADDR_W, 8, ROM address width; addresses wrap modulo 2^ADDR_W
TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz); must be >= 2
PERIOD_SHIFT, 4, left shift applied to the ROM half-period field; 0..16
GAP_TICKS, 1, muted ticks between notes; used only with SEQ_GAP_EN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  begin playback at start_addr; sampled only in IDLE
stop  in  1  abort playback; dominant over start
loop  in  1  at end marker: 1 = restart at start_addr, 0 = finish
start_addr  in  ADDR_W  first table entry
rom_addr  out  ADDR_W  ROM address, registered
rom_data  in  32  ROM word, valid one cycle after rom_addr changes
length1  out  32  high count to pulse generator
length2  out  32  low count to pulse generator
mute  out  1  1 = audio output gated off
pulse_rst  out  1  one-cycle strobe; pulse generator restarts phase
busy  out  1  1 in any state other than IDLE
done  out  1  one-cycle strobe at normal end of song

Behaviour:
- ROM word fields:
  - [31] end marker.
  - [30:16] duration in ticks.
  - [15:0] half-period H.
  - Other fields of an end-marker word are ignored.
- Reset values: rom_addr 0, length1 0, length2 0, mute 1, pulse_rst 0, busy 0, done 0, state IDLE, prescaler 0, duration counter 0.
- States:
  - IDLE: stop, or no start → stay. start && !stop → rom_addr<=start_addr, FETCH.
  - FETCH: one cycle, waiting for ROM latency. → LOAD.
  - LOAD: decode rom_data.
    - End marker, loop=1 → rom_addr<=start_addr, FETCH.
    - End marker, loop=0 → mute<=1, done<=1 for one cycle, IDLE.
    - Duration 0 → note skipped. rom_addr<=rom_addr+1, FETCH. Outputs unchanged, no pulse_rst.
    - H != 0 → length1<=length2<=(zero-extended H << PERIOD_SHIFT) - 1, 32-bit arithmetic. mute<=0, pulse_rst<=1 for one cycle, PLAY.
    - H == 0 (rest) → mute<=1, lengths held, no pulse_rst, PLAY.
    - In all PLAY cases: prescaler<=0, duration counter<=duration.
  - PLAY:
    - Prescaler counts 0..TICK_DIV-1; a tick fires on the count of TICK_DIV-1.
    - Each tick decrements the duration counter.
    - The tick taking it from 1 to 0 → rom_addr<=rom_addr+1, FETCH (or GAP under SEQ_GAP_EN).
    - PLAY therefore lasts exactly duration*TICK_DIV cycles.
- Latency:
  - Outputs for the first note update on the 2nd rising edge after the edge that samples start.
  - Note-to-note overhead is 2 cycles (FETCH+LOAD), during which the previous note continues to sound.
- stop in any non-IDLE state → IDLE on that edge. mute=1 and busy=0 from the next cycle; no done; lengths held.
- start while busy is ignored.
- reset mid-operation restores all reset values regardless of state.
- busy is combinational from state: 1 in FETCH/LOAD/PLAY/GAP.

Optional Feature:
SEQ_GAP_EN
- Defined:
  - When PLAY expires, the block enters GAP with mute=1 for GAP_TICKS ticks (prescaler restarted at 0), then FETCH.
  - stop applies in GAP.
  - A following rest or end marker leaves mute at 1.
- Undefined: GAP state absent, GAP_TICKS ignored, PLAY → FETCH directly.

Test Plan:
All scenarios use TICK_DIV=4, PERIOD_SHIFT=0, ADDR_W=2 unless noted.
1. Reset held 3 cycles → rom_addr 0, length1/length2 0, mute 1, pulse_rst 0, busy 0, done 0.
2. ROM[0]={0,dur 2,H 10}, ROM[1]=end; start_addr=0, loop=0, pulse start → two edges later length1=length2=9, mute 0, pulse_rst high exactly 1 cycle. Mute stays 0 for 8+2 cycles, then mute 1, done high 1 cycle, busy 0.
3. ROM[0]={dur 1,H 0}, ROM[1]={dur 1,H 5}, ROM[2]=end → rest: mute 1 for 4 PLAY cycles with lengths 0 and no pulse_rst. Then lengths 4, mute 0, pulse_rst once.
4. Scenario 2 table with loop=1 → rom_addr sequence 0,1,0,1,...; length pattern repeats every 12 cycles; done never asserts.
5. Stop asserted 3 cycles into PLAY → next cycle busy 0, mute 1, no done. Start and stop asserted together in IDLE → stays IDLE.
6. start_addr=3, ROM[3]={dur 0,H 7}, ROM[0]={dur 1,H 2}, ROM[1]=end → ROM[3] skipped with no output change, rom_addr wraps 3→0, lengths become 1. With SEQ_GAP_EN, GAP_TICKS=1: 4 extra muted cycles before the end marker is fetched.
